// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: control codes,
// flag bit positions and FSM state encoding.
package alu_arbiter_pkg;

    localparam logic [2:0] CTRL_NOP = 3'd0;
    localparam logic [2:0] CTRL_ADD = 3'd1;
    localparam logic [2:0] CTRL_SUB = 3'd2;
    localparam logic [2:0] CTRL_AND = 3'd3;
    localparam logic [2:0] CTRL_OR  = 3'd4;
    localparam logic [2:0] CTRL_XOR = 3'd5;
    localparam logic [2:0] CTRL_SLT = 3'd6;
    localparam logic [2:0] CTRL_SLL = 3'd7;

    // Bit positions inside the packed {Z,V,C,N} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant logic (pure combinational).
// Ports: valid0/valid1, last_grant, enable -> grant, grant_valid.
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (enable) begin
            unique case ({valid1, valid0})
                2'b01: begin
                    grant       = 1'b0;
                    grant_valid = 1'b1;
                end
                2'b10: begin
                    grant       = 1'b1;
                    grant_valid = 1'b1;
                end
                // Contention: whoever was not served last wins.
                2'b11: begin
                    grant       = ~last_grant;
                    grant_valid = 1'b1;
                end
                default: begin
                    grant       = 1'b0;
                    grant_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Ports: req0_*/req1_* in, alu_* to/from ALU, rsp_* response out.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op0,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op0,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [DATA_W-1:0] alu_operand0,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_Z,
    input  logic              alu_V,
    input  logic              alu_C,
    input  logic              alu_N,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags
);

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   grant_valid;
    logic   arb_en;

    // Gating with rst_n keeps both readies low while reset is held.
    assign arb_en = (state == ST_IDLE) && rst_n;

    rr_arbiter_2 u_rr (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .enable      (arb_en),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign req0_ready = grant_valid & ~grant;
    assign req1_ready = grant_valid & grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            alu_operand0 <= '0;
            alu_operand1 <= '0;
            alu_control  <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        alu_operand0 <= grant ? req1_op0 : req0_op0;
                        alu_operand1 <= grant ? req1_op1 : req0_op1;
                        alu_control  <= grant ? req1_ctrl : req0_ctrl;
                        rsp_id       <= grant;
                        last_grant   <= grant;
                        state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result        <= alu_result;
                    rsp_flags[FLAG_Z] <= alu_Z;
                    rsp_flags[FLAG_V] <= alu_V;
                    rsp_flags[FLAG_C] <= alu_C;
                    rsp_flags[FLAG_N] <= alu_N;
                    rsp_valid         <= 1'b1;
                    state             <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        alu_control  <= '0;
                        alu_operand0 <= '0;
                        alu_operand1 <= '0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    alu_operand0 <= '0;
                    alu_operand1 <= '0;
                    alu_control  <= '0;
                    rsp_valid    <= 1'b0;
                    rsp_id       <= 1'b0;
                    rsp_result   <= '0;
                    rsp_flags    <= '0;
                end
            endcase
        end
    end

endmodule
